// File: rtl/kernel_bank_mem_if.sv
// Bundle of write-side and read-side handshake signals for kernel_bank_mem.
// The slave modport is the memory; the master modport is the DMA/column side.
interface kernel_bank_mem_if #(
  parameter int GROUP_NB    = 4,
  parameter int KER_WIDTH   = 16,
  parameter int DEPTH_NB    = 16,
  parameter int MEM_AWIDTH  = 10,
  parameter int BANK_AWIDTH = 1,
  parameter int LOOP_WIDTH  = 8
);
  localparam int DW      = GROUP_NB * KER_WIDTH * DEPTH_NB;
  localparam int BANK_NB = 1 << BANK_AWIDTH;

  logic [BANK_AWIDTH-1:0] wr_cfg_bank;
  logic [MEM_AWIDTH-1:0]  wr_cfg_end;
  logic                   wr_cfg_set;
  logic                   wr_cfg_rdy;
  logic [DW-1:0]          wr_data;
  logic                   wr_data_val;
  logic                   wr_data_rdy;

  logic [BANK_AWIDTH-1:0] rd_cfg_bank;
  logic [MEM_AWIDTH-1:0]  rd_cfg_start;
  logic [MEM_AWIDTH-1:0]  rd_cfg_end;
  logic [LOOP_WIDTH-1:0]  rd_cfg_loops;
  logic                   rd_cfg_set;
  logic                   rd_cfg_rdy;
  logic [DW-1:0]          rd_bias;
  logic [DW-1:0]          rd_data;
  logic                   rd_data_val;
  logic                   rd_data_rdy;
  logic                   rd_done;
  logic [BANK_NB-1:0]     bank_full;

  modport slave (
    input  wr_cfg_bank, wr_cfg_end, wr_cfg_set, wr_data, wr_data_val,
    input  rd_cfg_bank, rd_cfg_start, rd_cfg_end, rd_cfg_loops, rd_cfg_set, rd_data_rdy,
    output wr_cfg_rdy, wr_data_rdy,
    output rd_cfg_rdy, rd_bias, rd_data, rd_data_val, rd_done, bank_full
  );

  modport master (
    output wr_cfg_bank, wr_cfg_end, wr_cfg_set, wr_data, wr_data_val,
    output rd_cfg_bank, rd_cfg_start, rd_cfg_end, rd_cfg_loops, rd_cfg_set, rd_data_rdy,
    input  wr_cfg_rdy, wr_data_rdy,
    input  rd_cfg_rdy, rd_bias, rd_data, rd_data_val, rd_done, bank_full
  );
endinterface

// File: rtl/kernel_bank_mem.sv
// Multi-bank ping-pong kernel/bias store: one bank fills while another streams.
// Optional macro KERNEL_MEM_STALL_CNT_EN adds a saturating rd_stall_cnt output.
module kernel_bank_mem #(
  parameter int GROUP_NB    = 4,
  parameter int KER_WIDTH   = 16,
  parameter int DEPTH_NB    = 16,
  parameter int MEM_AWIDTH  = 10,
  parameter int BANK_AWIDTH = 1,
  parameter int LOOP_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  kernel_bank_mem_if.slave    kb
`ifdef KERNEL_MEM_STALL_CNT_EN
  ,
  output logic [31:0]         rd_stall_cnt
`endif
);
  localparam int DW      = GROUP_NB * KER_WIDTH * DEPTH_NB;
  localparam int BANK_NB = 1 << BANK_AWIDTH;
  localparam int DEPTH   = 1 << MEM_AWIDTH;

  typedef logic [MEM_AWIDTH-1:0]  addr_t;
  typedef logic [BANK_AWIDTH-1:0] bank_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_FILL} w_state_e;
  typedef enum logic [2:0] {R_IDLE, R_WAIT, R_BIAS, R_STREAM, R_DONE} r_state_e;

  logic [DW-1:0] mem [BANK_NB*DEPTH];

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  bank_t    w_bank_q, r_bank_q;
  addr_t    w_end_q, w_ptr_q;
  addr_t    r_start_q, r_end_q, r_ptr_q, r_raddr;
  logic [LOOP_WIDTH-1:0] loops_left_q;
  logic [BANK_NB-1:0]    bank_full_q, bank_full_d;
  logic [DW-1:0]         rd_data_q, rd_bias_q;
  logic bias_ph_q, issue_done_q, rd_val_q;
  logic w_cfg_acc, w_beat, w_last, w_go, rd_active;
  logic r_cfg_acc, r_issue, r_issue_stream, r_accept, r_final;

  assign w_cfg_acc = kb.wr_cfg_set & (w_state_q == W_IDLE);
  assign w_beat    = kb.wr_data_val & (w_state_q == W_FILL);
  assign w_last    = w_beat & (w_ptr_q == w_end_q);
  assign rd_active = (r_state_q == R_BIAS) | (r_state_q == R_STREAM) | (r_state_q == R_DONE);
  assign w_go      = ~bank_full_q[w_bank_q] & ~(rd_active & (r_bank_q == w_bank_q));

  assign r_cfg_acc      = kb.rd_cfg_set & (r_state_q == R_IDLE);
  assign r_accept       = rd_val_q & kb.rd_data_rdy;
  assign r_issue_stream = (r_state_q == R_STREAM) & ~issue_done_q & (~rd_val_q | kb.rd_data_rdy);
  assign r_issue        = ((r_state_q == R_BIAS) & ~bias_ph_q) | r_issue_stream;
  assign r_final        = (r_state_q == R_STREAM) & issue_done_q & r_accept;
  assign r_raddr        = (r_state_q == R_BIAS) ? r_start_q : r_ptr_q;

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      bank_full_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      bank_full_q <= bank_full_d;
    end
  end

  // NOTE: each combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (w_cfg_acc) w_state_d = W_WAIT;
      W_WAIT:  if (w_go)      w_state_d = W_FILL;
      W_FILL:  if (w_last)    w_state_d = W_IDLE;
      default:                w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:   if (r_cfg_acc)              r_state_d = R_WAIT;
      R_WAIT:   if (bank_full_q[r_bank_q])  r_state_d = R_BIAS;
      R_BIAS:   if (bias_ph_q)              r_state_d = (r_end_q == r_start_q) ? R_DONE : R_STREAM;
      R_STREAM: if (r_final)                r_state_d = R_DONE;
      R_DONE:                               r_state_d = R_IDLE;
      default:                              r_state_d = R_IDLE;
    endcase
  end

  // Write and read never target the same bank in one cycle, so set/clear cannot collide.
  always_comb begin
    bank_full_d = bank_full_q;
    if (w_last)              bank_full_d[w_bank_q] = 1'b1;
    if (r_state_q == R_DONE) bank_full_d[r_bank_q] = 1'b0;
  end

  always_comb begin
    kb.wr_cfg_rdy  = (w_state_q == W_IDLE);
    kb.wr_data_rdy = (w_state_q == W_FILL);
    kb.rd_cfg_rdy  = (r_state_q == R_IDLE);
    kb.rd_done     = (r_state_q == R_DONE);
    kb.rd_data_val = rd_val_q;
    kb.rd_data     = rd_data_q;
    kb.rd_bias     = rd_bias_q;
    kb.bank_full   = bank_full_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_bank_q <= '0;
      w_end_q  <= '0;
      w_ptr_q  <= '0;
    end else begin
      if (w_cfg_acc) begin
        w_bank_q <= kb.wr_cfg_bank;
        w_end_q  <= kb.wr_cfg_end;
      end
      if (w_state_q == W_WAIT) w_ptr_q <= '0;
      else if (w_beat)         w_ptr_q <= w_ptr_q + addr_t'(1);
    end
  end

  // NOTE: the storage array has no reset; its contents survive rst and only
  // the control state around it is cleared.
  always_ff @(posedge clk) begin
    if (w_beat) mem[{w_bank_q, w_ptr_q}] <= kb.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank_q     <= '0;
      r_start_q    <= '0;
      r_end_q      <= '0;
      r_ptr_q      <= '0;
      loops_left_q <= '0;
      bias_ph_q    <= 1'b0;
      issue_done_q <= 1'b0;
      rd_val_q     <= 1'b0;
      rd_data_q    <= '0;
      rd_bias_q    <= '0;
    end else begin
      if (r_cfg_acc) begin
        r_bank_q     <= kb.rd_cfg_bank;
        r_start_q    <= kb.rd_cfg_start;
        r_end_q      <= kb.rd_cfg_end;
        loops_left_q <= (kb.rd_cfg_loops == '0) ? LOOP_WIDTH'(1) : kb.rd_cfg_loops;
      end
      bias_ph_q <= (r_state_q == R_BIAS) ? ~bias_ph_q : 1'b0;
      // Bias word lands in rd_data_q one cycle after its read; copy it out.
      if ((r_state_q == R_BIAS) && bias_ph_q) begin
        rd_bias_q    <= rd_data_q;
        r_ptr_q      <= r_start_q + addr_t'(1);
        issue_done_q <= 1'b0;
      end
      if (r_issue) rd_data_q <= mem[{r_bank_q, r_raddr}];
      if (r_issue_stream) begin
        rd_val_q <= 1'b1;
        if (r_ptr_q == r_end_q) begin
          if (loops_left_q > LOOP_WIDTH'(1)) begin
            loops_left_q <= loops_left_q - LOOP_WIDTH'(1);
            r_ptr_q      <= r_start_q + addr_t'(1);
          end else begin
            issue_done_q <= 1'b1;
          end
        end else begin
          r_ptr_q <= r_ptr_q + addr_t'(1);
        end
      end else if (r_accept) begin
        rd_val_q <= 1'b0;
      end
    end
  end

`ifdef KERNEL_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          stall_cnt_q <= '0;
    else if (r_cfg_acc)                               stall_cnt_q <= '0;
    else if (rd_val_q & ~kb.rd_data_rdy & ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign rd_stall_cnt = stall_cnt_q;
`else
  // Stall counter not built.
`endif
endmodule
